// File: rtl/stack_ram_pkg.sv
// Shared types and helpers for the stack/fetch RAM responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stack_ram_pkg;

    localparam int WORD_W    = 16;
    localparam int LINE_W    = 256;
    localparam int MAX_WORDS = 16;

    // FSM encoding kept as plain constants so older tools and dumps read the same values
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_RD_RUN  = 3'd1;
    localparam state_t ST_RD_DONE = 3'd2;
    localparam state_t ST_WR_RUN  = 3'd3;
    localparam state_t ST_WR_DONE = 3'd4;

    // Words moved for a byte length: round odd bytes up, cap at one full line
    function automatic logic [4:0] word_count(input logic [15:0] bytes);
        logic [16:0] w_half;
        w_half = ({1'b0, bytes} + 17'd1) >> 1;
        return (w_half > 17'd16) ? 5'd16 : w_half[4:0];
    endfunction

endpackage

// File: rtl/stack_ram_responder_if.sv
// Start/done RAM request bus between the CPU initiator and the memory responder.
// Latency: n/a (wiring only).
// Backpressure: level handshake; start held until done seen, done held until start drops.
interface stack_ram_responder_if;
    import stack_ram_pkg::*;

    logic              rd_start;
    logic [15:0]       rd_address;
    logic [15:0]       rd_bytes;
    logic [LINE_W-1:0] rd_q;
    logic              rd_done;
    logic              wr_start;
    logic [15:0]       wr_address;
    logic [15:0]       wr_bytes;
    logic [LINE_W-1:0] wr_data;
    logic              wr_done;
    logic              busy;

    modport master (
        output rd_start, rd_address, rd_bytes, wr_start, wr_address, wr_bytes, wr_data,
        input  rd_q, rd_done, wr_done, busy
    );

    modport slave (
        input  rd_start, rd_address, rd_bytes, wr_start, wr_address, wr_bytes, wr_data,
        output rd_q, rd_done, wr_done, busy
    );

endinterface

// File: rtl/word_ram_1rw.sv
// Single-port synchronous word RAM, no reset, shaped for block-RAM inference.
// Latency: read data valid one cycle after the enabled read edge.
// Backpressure: none; accepts one access per cycle.
module word_ram_1rw #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdat,
    output logic [DATA_W-1:0] o_rdat
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdat;

    // One access per edge: write, or registered read
    always_ff @(posedge clock) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdat;
            end else begin
                r_rdat <= r_mem[i_addr];
            end
        end
    end

    assign o_rdat = r_rdat;

endmodule

// File: rtl/stack_ram_responder.sv
// Serves one read and one write channel of line transfers against a single word RAM.
// Latency: read done N+2 edges, write done N+1 edges after the start is sampled (1 edge for N=0).
// Backpressure: one transfer at a time, write preferred; done held until start drops.
module stack_ram_responder #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clock,
    input  logic                  reset_n,
    stack_ram_responder_if.slave  bus
);
    import stack_ram_pkg::*;

    state_t                r_state;
    logic [4:0]            r_cnt;
    logic [4:0]            r_n;
    logic [DEPTH_LOG2-1:0] r_base;
    logic                  r_cap_vld;
    logic [3:0]            r_cap_idx;
    logic [LINE_W-1:0]     r_rd_q;

    logic                  w_rd_issue;
    logic                  w_wr_issue;
    logic                  w_rd_accept;
    logic [DEPTH_LOG2-1:0] w_addr;
    logic [LINE_W-1:0]     w_wr_line;
    logic [WORD_W-1:0]     w_wdat;
    logic [WORD_W-1:0]     w_rdat;

    // An access is only issued while the initiator still holds its start; dropping it aborts cleanly
    assign w_rd_issue  = (r_state == ST_RD_RUN) && bus.rd_start && (r_cnt < r_n);
    assign w_wr_issue  = (r_state == ST_WR_RUN) && bus.wr_start && (r_cnt < r_n);
    assign w_rd_accept = (r_state == ST_IDLE) && !bus.wr_start && bus.rd_start;
    assign w_addr      = r_base + DEPTH_LOG2'(r_cnt);

    // Word k is the MSB-first slot; shift it to the top of the line to pick it
    assign w_wr_line   = bus.wr_data << {r_cnt[3:0], 4'b0000};
    assign w_wdat      = w_wr_line[LINE_W-1 -: WORD_W];

    word_ram_1rw #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (WORD_W)
    ) u_ram (
        .clock  (clock),
        .i_en   (w_rd_issue | w_wr_issue),
        .i_we   (w_wr_issue),
        .i_addr (w_addr),
        .i_wdat (w_wdat),
        .o_rdat (w_rdat)
    );

    // Transfer sequencing: accept, walk the word counter, hold done until start drops
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_n     <= '0;
            r_base  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (bus.wr_start) begin
                        r_state <= ST_WR_RUN;
                        r_base  <= bus.wr_address[4 +: DEPTH_LOG2];
                        r_n     <= word_count(bus.wr_bytes);
                    end else if (bus.rd_start) begin
                        r_state <= ST_RD_RUN;
                        r_base  <= bus.rd_address[4 +: DEPTH_LOG2];
                        r_n     <= word_count(bus.rd_bytes);
                    end
                end
                ST_RD_RUN: begin
                    if (!bus.rd_start) begin
                        r_state <= ST_IDLE;
                    end else if ((r_cnt == r_n) && !r_cap_vld) begin
                        // last RAM word has landed in rd_q
                        r_state <= ST_RD_DONE;
                    end else if (w_rd_issue) begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                ST_WR_RUN: begin
                    if (!bus.wr_start) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == r_n) begin
                        r_state <= ST_WR_DONE;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                ST_RD_DONE: begin
                    if (!bus.rd_start) r_state <= ST_IDLE;
                end
                ST_WR_DONE: begin
                    if (!bus.wr_start) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Read data path: remember which slot each issued read belongs to, drop it in one cycle later
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cap_vld <= 1'b0;
            r_cap_idx <= '0;
            r_rd_q    <= '0;
        end else begin
            r_cap_vld <= w_rd_issue;
            r_cap_idx <= r_cnt[3:0];
            if (w_rd_accept) begin
                r_rd_q <= '0;
            end else if (r_cap_vld) begin
                for (int k = 0; k < MAX_WORDS; k++) begin
                    if (r_cap_idx == 4'(k)) r_rd_q[LINE_W-1-WORD_W*k -: WORD_W] <= w_rdat;
                end
            end
        end
    end

    assign bus.rd_q    = r_rd_q;
    assign bus.rd_done = (r_state == ST_RD_DONE);
    assign bus.wr_done = (r_state == ST_WR_DONE);
    assign bus.busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_stack_ram_responder.sv
// Directed bench for the stack RAM responder with a reference word memory and result queues.
// Latency: checks done timing in edges counted from the sampling edge.
// Backpressure: drives the start/done handshake as an initiator would.
module tb_stack_ram_responder;

    logic clk;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    logic [15:0]  model [4096];
    logic [255:0] line_q [$];
    int           lat_q  [$];

    stack_ram_responder_if bus ();

    stack_ram_responder #(.DEPTH_LOG2(12)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int words_for(input logic [15:0] bytes);
        int n;
        n = (int'(bytes) + 1) / 2;
        return (n > 16) ? 16 : n;
    endfunction

    function automatic logic [255:0] exp_line(input logic [15:0] addr, input logic [15:0] bytes);
        logic [255:0] l;
        int           n;
        l = '0;
        n = words_for(bytes);
        for (int k = 0; k < n; k++) l[255-16*k -: 16] = model[(int'(addr[15:4]) + k) % 4096];
        return l;
    endfunction

    task automatic model_write(input logic [15:0] addr, input logic [15:0] bytes, input logic [255:0] line);
        int n;
        n = words_for(bytes);
        for (int k = 0; k < n; k++) model[(int'(addr[15:4]) + k) % 4096] = line[255-16*k -: 16];
    endtask

    // Ticks until the chosen done is seen; returns -1 if the budget runs out
    task automatic wait_done(input bit is_rd, input int limit, output int ticks);
        ticks = 0;
        while (ticks < limit) begin
            tick();
            ticks++;
            if (is_rd ? bus.rd_done : bus.wr_done) return;
        end
        ticks = -1;
    endtask

    task automatic do_write(input string tag, input logic [15:0] addr, input logic [15:0] bytes,
                            input logic [255:0] line);
        int t;
        bus.wr_address = addr;
        bus.wr_bytes   = bytes;
        bus.wr_data    = line;
        bus.wr_start   = 1'b1;
        lat_q.push_back(words_for(bytes) + 1);
        wait_done(1'b0, 60, t);
        check({tag, "_wr_lat"}, 256'(t - 1), 256'(lat_q.pop_front()));
        model_write(addr, bytes, line);
        bus.wr_start = 1'b0;
        tick();
        check({tag, "_wr_drop"}, 256'({bus.wr_done, bus.busy}), 256'(0));
    endtask

    task automatic do_read(input string tag, input logic [15:0] addr, input logic [15:0] bytes);
        int t;
        int n;
        n = words_for(bytes);
        bus.rd_address = addr;
        bus.rd_bytes   = bytes;
        bus.rd_start   = 1'b1;
        line_q.push_back(exp_line(addr, bytes));
        lat_q.push_back((n == 0) ? 1 : n + 2);
        wait_done(1'b1, 60, t);
        check({tag, "_rd_lat"}, 256'(t - 1), 256'(lat_q.pop_front()));
        check({tag, "_rd_q"}, bus.rd_q, line_q.pop_front());
        bus.rd_start = 1'b0;
        tick();
        check({tag, "_rd_drop"}, 256'({bus.rd_done, bus.busy}), 256'(0));
    endtask

    initial begin
        logic [255:0] line;
        logic [255:0] old_line;
        int           t;

        rst_n          = 1'b0;
        bus.rd_start   = 1'b0;
        bus.rd_address = '0;
        bus.rd_bytes   = '0;
        bus.wr_start   = 1'b0;
        bus.wr_address = '0;
        bus.wr_bytes   = '0;
        bus.wr_data    = '0;
        #3;
        check("reset_rd_q", bus.rd_q, 256'(0));
        check("reset_flags", 256'({bus.rd_done, bus.wr_done, bus.busy}), 256'(0));
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();

        // single word write then read back
        line = {16'hBEEF, 240'h0};
        do_write("t1", 16'd16, 16'd1, line);
        do_read("t1", 16'd16, 16'd1);

        // full line write and read back
        for (int k = 0; k < 16; k++) line[255-16*k -: 16] = 16'(k);
        do_write("t2", 16'd256, 16'd32, line);
        do_read("t2", 16'd256, 16'd32);

        // simultaneous starts: write served first, read follows with the new word
        line = {16'h1234, 240'h0};
        bus.wr_address = 16'd0;
        bus.wr_bytes   = 16'd2;
        bus.wr_data    = line;
        bus.rd_address = 16'd0;
        bus.rd_bytes   = 16'd2;
        bus.wr_start   = 1'b1;
        bus.rd_start   = 1'b1;
        model_write(16'd0, 16'd2, line);
        line_q.push_back(exp_line(16'd0, 16'd2));
        wait_done(1'b0, 60, t);
        check("t3_wr_first_lat", 256'(t - 1), 256'(2));
        check("t3_rd_idle", 256'(bus.rd_done), 256'(0));
        bus.wr_start = 1'b0;
        wait_done(1'b1, 60, t);
        check("t3_rd_lat", 256'(t), 256'(5));
        check("t3_rd_q", bus.rd_q, line_q.pop_front());
        bus.rd_start = 1'b0;
        tick();

        // address wrap at the top of RAM
        line = {16'hAAAA, 16'h5555, 224'h0};
        do_write("t4", 16'hFFF0, 16'd4, line);
        do_read("t4_low", 16'd0, 16'd2);
        do_read("t4_wrap", 16'hFFF0, 16'd4);

        // asynchronous reset in the middle of a line read
        bus.rd_address = 16'd256;
        bus.rd_bytes   = 16'd32;
        bus.rd_start   = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_rd_q", bus.rd_q, 256'(0));
        check("t5_rst_flags", 256'({bus.rd_done, bus.busy}), 256'(0));
        bus.rd_start = 1'b0;
        tick();
        #2 rst_n = 1'b1;
        tick();
        do_read("t5_after", 16'd256, 16'd32);

        // zero-length read clears the line that the previous read left behind
        do_read("t6_zero", 16'd256, 16'd0);

        // write aborted after three words
        for (int k = 0; k < 16; k++) old_line[255-16*k -: 16] = 16'h1100 + 16'(k);
        do_write("t6_pre", 16'd512, 16'd32, old_line);
        for (int k = 0; k < 16; k++) line[255-16*k -: 16] = 16'hA000 + 16'(k);
        bus.wr_address = 16'd512;
        bus.wr_bytes   = 16'd32;
        bus.wr_data    = line;
        bus.wr_start   = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bus.wr_start = 1'b0;
        tick();
        check("t6_abort_flags", 256'({bus.wr_done, bus.busy}), 256'(0));
        model_write(16'd512, 16'd6, line);
        do_read("t6_abort", 16'd512, 16'd32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
